// File: rtl/uart_bus_model_pkg.sv
// -----------------------------------------------------------------------------
// uart_model_defs
//   Shared definitions for the UART bus model: transmit state encodings,
//   sticky error flag bit positions and a small constant-expression helper.
// -----------------------------------------------------------------------------
package uart_model_defs;

  // Transmit path states, as seen through tbre/tsre.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,  // tbre=1, tsre=1
    TX_HOLD  = 2'd1,  // tbre=0, tsre=0, holding register occupied
    TX_SHIFT = 2'd2   // tbre=1, tsre=0, shift register still busy
  } tx_state_e;

  // Bit positions inside the sticky err vector.
  localparam int ERR_TX_OVERFLOW  = 0;  // TX capture FIFO full when the byte arrived
  localparam int ERR_TX_OVERRUN   = 1;  // write strobe while the holding register was busy
  localparam int ERR_RX_UNDERFLOW = 2;  // read strobe with the RX FIFO empty
  localparam int ERR_W            = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_bus_model_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO used for both the RX (host -> CPU) and TX capture
//   (CPU -> host) byte queues. Push and pop in the same cycle are both
//   honoured; a push into a full FIFO is accepted only if a pop frees the slot
//   in that same cycle. Pops of an empty FIFO are ignored.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   push, push_data  write request and data
//   pop              read request (head advances on the clock edge)
//   pop_data         current head entry (valid when !empty)
//   full, empty      occupancy flags, derived from the registered count
//   count            number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
      else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are meaningful, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_bus_model.sv
// -----------------------------------------------------------------------------
// uart_bus_model
//   Cycle-accurate model of the board UART as seen on the CPU data bus.
//   Answers the active-low rdn/wrn strobes, buffers host-injected RX bytes,
//   captures CPU-written TX bytes and drives data_ready/tbre/tsre with
//   realistic transmit timing.
//
// Ports:
//   clk, rst              model clock, asynchronous active-low reset
//   data_i                bus value sampled on CPU writes (low DATA_W bits used)
//   data_o, data_oe       read data (zero-extended RX head) and bus drive enable
//   rdn, wrn              CPU read/write strobes, active low, asynchronous
//   data_ready            RX FIFO non-empty
//   tbre, tsre            transmit holding / shift register empty
//   inj_valid/data/ready  host -> RX FIFO handshake
//   cap_valid/data/ready  TX FIFO -> host handshake
//   rx_count, tx_count    FIFO occupancies
//   err                   sticky {rx_underflow, tx_overrun, tx_overflow}
// -----------------------------------------------------------------------------
module uart_bus_model
  import uart_model_defs::*;
#(
  parameter int BUS_W       = 16,
  parameter int DATA_W      = 8,
  parameter int RX_DEPTH    = 16,
  parameter int TX_DEPTH    = 16,
  parameter int TX_DELAY    = 8,
  parameter int TSRE_DELAY  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BUS_W-1:0]          data_i,
  output logic [BUS_W-1:0]          data_o,
  output logic                      data_oe,
  input  logic                      rdn,
  input  logic                      wrn,
  output logic                      data_ready,
  output logic                      tbre,
  output logic                      tsre,
  input  logic                      inj_valid,
  input  logic [DATA_W-1:0]         inj_data,
  output logic                      inj_ready,
  output logic                      cap_valid,
  output logic [DATA_W-1:0]         cap_data,
  input  logic                      cap_ready,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic [$clog2(TX_DEPTH):0] tx_count,
  output logic [ERR_W-1:0]          err
);

  localparam int CNT_W = $clog2(max_int(TX_DELAY, TSRE_DELAY) + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(TX_DELAY - 1);
  localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(TSRE_DELAY - 1);

  // ---------------------------------------------------------------------------
  // Strobe synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] rdn_sync;
  logic [SYNC_STAGES-1:0] wrn_sync;
  logic                   rdn_last;
  logic                   wrn_last;
  logic                   rd_act;
  logic                   rd_rise;
  logic                   wr_rise;

  // The chains reset to the inactive (high) level so that leaving reset can
  // never look like a strobe edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdn_sync <= '1;
      wrn_sync <= '1;
      rdn_last <= 1'b1;
      wrn_last <= 1'b1;
    end else begin
      rdn_sync[0] <= rdn;
      wrn_sync[0] <= wrn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rdn_sync[i] <= rdn_sync[i-1];
        wrn_sync[i] <= wrn_sync[i-1];
      end
      rdn_last <= rdn_sync[SYNC_STAGES-1];
      wrn_last <= wrn_sync[SYNC_STAGES-1];
    end
  end

  assign rd_act  = !rdn_sync[SYNC_STAGES-1];
  assign rd_rise = rdn_sync[SYNC_STAGES-1] && !rdn_last;
  assign wr_rise = wrn_sync[SYNC_STAGES-1] && !wrn_last;

  // Only the low DATA_W bits of the bus carry the UART byte.
  logic unused_bus;
  assign unused_bus = ^data_i;

  // ---------------------------------------------------------------------------
  // RX path: host injects, CPU reads
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rx_head;
  logic              rx_full;
  logic              rx_empty;
  logic              rx_push;

  assign inj_ready  = !rx_full;
  assign rx_push    = inj_valid && inj_ready;
  assign data_ready = !rx_empty;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (inj_data),
    .pop       (rd_rise),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // The bus is released in the same cycle the strobe's rising edge pops the
  // FIFO, because rd_act falls exactly when rd_rise is seen.
  assign data_oe = rd_act;
  assign data_o  = (rd_act && !rx_empty) ? BUS_W'(rx_head) : '0;

  // ---------------------------------------------------------------------------
  // TX state machine
  // ---------------------------------------------------------------------------
  tx_state_e         state;
  tx_state_e         state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic [DATA_W-1:0] tx_hold;
  logic [DATA_W-1:0] tx_hold_n;
  logic              hold_expire;
  logic              overrun;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      tx_hold <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      tx_hold <= tx_hold_n;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    tx_hold_n   = tx_hold;
    hold_expire = 1'b0;
    overrun     = 1'b0;
    case (state)
      TX_IDLE: begin
        if (wr_rise) begin
          state_n   = TX_HOLD;
          cnt_n     = HOLD_LOAD;
          tx_hold_n = data_i[DATA_W-1:0];
        end
      end
      TX_HOLD: begin
        // A write while the holding register is busy is lost.
        overrun = wr_rise;
        if (cnt == '0) begin
          hold_expire = 1'b1;
          state_n     = TX_SHIFT;
          cnt_n       = SHIFT_LOAD;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      TX_SHIFT: begin
        // The holding register is free again, so a new write restarts HOLD.
        if (wr_rise) begin
          state_n   = TX_HOLD;
          cnt_n     = HOLD_LOAD;
          tx_hold_n = data_i[DATA_W-1:0];
        end else if (cnt == '0) begin
          state_n = TX_IDLE;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

  assign tbre = (state != TX_HOLD);
  assign tsre = (state == TX_IDLE);

  // ---------------------------------------------------------------------------
  // TX capture FIFO
  // ---------------------------------------------------------------------------
  logic tx_full;
  logic tx_empty;
  logic tx_pop;

  assign cap_valid = !tx_empty;
  assign tx_pop    = cap_valid && cap_ready;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (hold_expire),
    .push_data (tx_hold),
    .pop       (tx_pop),
    .pop_data  (cap_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  logic [ERR_W-1:0] err_set;

  assign err_set[ERR_RX_UNDERFLOW] = rd_rise && rx_empty;
  assign err_set[ERR_TX_OVERRUN]   = overrun;
  assign err_set[ERR_TX_OVERFLOW]  = hold_expire && tx_full && !tx_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= '0;
    else      err <= err | err_set;
  end

endmodule

// File: tb/tb_uart_bus_model.sv
// -----------------------------------------------------------------------------
// tb_uart_bus_model
//   Self-checking bench for uart_bus_model. The stimulus process keeps a
//   transaction-level model (RX byte queue, list of accepted TX bytes, the
//   window in which a new write would be lost, expected error flags) and
//   pushes expected read/capture bytes into queues; an independent monitor
//   compares them whenever the DUT drives the bus or presents a captured byte.
// -----------------------------------------------------------------------------
module tb_uart_bus_model;

  localparam int BUS_W       = 16;
  localparam int DATA_W      = 8;
  localparam int RX_DEPTH    = 16;
  localparam int TX_DEPTH    = 16;
  localparam int TX_DELAY    = 8;
  localparam int TSRE_DELAY  = 16;
  localparam int SYNC_STAGES = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [BUS_W-1:0]  data_i;
  logic [BUS_W-1:0]  data_o;
  logic              data_oe;
  logic              rdn;
  logic              wrn;
  logic              data_ready;
  logic              tbre;
  logic              tsre;
  logic              inj_valid;
  logic [DATA_W-1:0] inj_data;
  logic              inj_ready;
  logic              cap_valid;
  logic [DATA_W-1:0] cap_data;
  logic              cap_ready;
  logic [4:0]        rx_count;
  logic [4:0]        tx_count;
  logic [2:0]        err;

  uart_bus_model #(
    .BUS_W       (BUS_W),
    .DATA_W      (DATA_W),
    .RX_DEPTH    (RX_DEPTH),
    .TX_DEPTH    (TX_DEPTH),
    .TX_DELAY    (TX_DELAY),
    .TSRE_DELAY  (TSRE_DELAY),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .data_o     (data_o),
    .data_oe    (data_oe),
    .rdn        (rdn),
    .wrn        (wrn),
    .data_ready (data_ready),
    .tbre       (tbre),
    .tsre       (tsre),
    .inj_valid  (inj_valid),
    .inj_data   (inj_data),
    .inj_ready  (inj_ready),
    .cap_valid  (cap_valid),
    .cap_data   (cap_data),
    .cap_ready  (cap_ready),
    .rx_count   (rx_count),
    .tx_count   (tx_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model and scoreboard state
  logic [7:0] rx_model[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] exp_cap_q[$];
  logic [2:0] err_model  = 3'b000;
  int         hold_until = -1000;
  bit         cap_enable = 1'b1;
  int         checks     = 0;
  int         errors     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: bus reads and TX captures
  // ---------------------------------------------------------------------------
  logic oe_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      oe_prev   = 1'b0;
      cap_ready = 1'b0;
    end else begin
      if (data_oe && !oe_prev) begin
        if (exp_rd_q.size() == 0) fail("rd_unexpected");
        else check("rd_data", data_o, {8'h00, exp_rd_q.pop_front()});
      end
      oe_prev = data_oe;
      cap_ready = cap_enable && cap_valid && ($urandom_range(0, 3) != 0);
      if (cap_ready) begin
        if (exp_cap_q.size() == 0) fail("cap_unexpected");
        else check("cap_data", cap_data, exp_cap_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks (each updates the reference model)
  // ---------------------------------------------------------------------------
  task automatic inject(input logic [7:0] v);
    @(negedge clk);
    inj_valid = 1'b1;
    inj_data  = v;
    if (rx_model.size() < RX_DEPTH) rx_model.push_back(v);
    @(negedge clk);
    inj_valid = 1'b0;
  endtask

  task automatic cpu_read();
    @(negedge clk);
    rdn = 1'b0;
    if (rx_model.size() > 0) exp_rd_q.push_back(rx_model.pop_front());
    else begin
      exp_rd_q.push_back(8'h00);
      err_model[2] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rdn = 1'b1;
    repeat (SYNC_STAGES + 3) @(negedge clk);
  endtask

  // The write takes effect SYNC_STAGES+1 edges after wrn rises; it is lost if
  // that edge falls inside the TX_DELAY-long hold window of the last accepted write.
  task automatic wr_pulse(input logic [15:0] v, input int low);
    int eff;
    @(negedge clk);
    data_i = v;
    wrn    = 1'b0;
    repeat (low) @(negedge clk);
    wrn = 1'b1;
    eff = cyc + SYNC_STAGES + 1;
    if (eff > hold_until) begin
      exp_cap_q.push_back(v[7:0]);
      hold_until = eff + TX_DELAY;
    end else begin
      err_model[1] = 1'b1;
    end
  endtask

  task automatic cpu_write(input logic [15:0] v, input int low);
    wr_pulse(v, low);
    repeat (SYNC_STAGES + 2) @(negedge clk);
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_rx_count"}, rx_count, rx_model.size());
    check({tag, "_data_ready"}, data_ready, rx_model.size() != 0);
    check({tag, "_inj_ready"}, inj_ready, rx_model.size() < RX_DEPTH);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_cap_q.size() != 0 || exp_rd_q.size() != 0 || !tsre) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail({tag, "_drain_timeout"});
    repeat (2) @(negedge clk);
    check({tag, "_tx_count"}, tx_count, 0);
    check({tag, "_err"}, err, err_model);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    rst = 1'b0; rdn = 1'b1; wrn = 1'b1; data_i = '0;
    inj_valid = 1'b0; inj_data = '0; cap_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Reset / idle state
    check("idle_tbre", tbre, 1);
    check("idle_tsre", tsre, 1);
    check("idle_data_oe", data_oe, 0);
    check("idle_data_o", data_o, 0);
    check("idle_cap_valid", cap_valid, 0);
    check("idle_tx_count", tx_count, 0);
    check("idle_err", err, 0);
    check_rx("idle");

    // Two injected bytes read back in order
    inject(8'h41);
    inject(8'h42);
    check_rx("inj2");
    cpu_read();
    check_rx("rd1");
    cpu_read();
    check_rx("rd2");

    // Single write with transmit timing measurement
    cap_enable = 1'b0;
    wr_pulse(16'h1234, 3);
    n = 0;
    while (tbre && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) fail("tbre_fall_timeout");
    n = 0;
    while (!tbre && n < 50) begin n++; @(negedge clk); end
    check("tbre_low_cycles", n, TX_DELAY);
    check("cap_valid_at_tbre_rise", cap_valid, 1);
    check("cap_data_direct", cap_data, 8'h34);
    n = 0;
    while (!tsre && n < 50) begin n++; @(negedge clk); end
    check("tsre_after_tbre_cycles", n, TSRE_DELAY);
    cap_enable = 1'b1;
    drain("wr1");

    // Overrun: second write lands while the first is held
    cpu_write(16'hAAC3, 3);
    cpu_write(16'h5566, 1);
    drain("overrun");
    check("overrun_flag", err[1], 1);

    // Fill RX FIFO, then refill while popping
    for (int i = 0; i < RX_DEPTH; i++) inject(8'(8'h60 + i));
    check_rx("full");
    inject(8'hEE);
    check_rx("full_reject");
    @(negedge clk);
    inj_valid = 1'b1;
    inj_data  = 8'h5A;
    cpu_read();
    rx_model.push_back(8'h5A);
    inj_valid = 1'b0;
    check_rx("refill");
    while (rx_model.size() > 0) cpu_read();
    check_rx("emptied");

    // Underflow read
    cpu_read();
    check("underflow_flag", err[2], 1);
    check_rx("underflow");

    // Randomised mix
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin inject(8'($urandom)); check_rx("rnd_inj"); end
        1: begin cpu_read(); check_rx("rnd_rd"); end
        2: cpu_write(16'($urandom), $urandom_range(1, 4));
        default: repeat ($urandom_range(0, 12)) @(negedge clk);
      endcase
    end
    drain("rnd");
    while (rx_model.size() > 0) cpu_read();
    check_rx("rnd_end");

    // Reset while the holding register is occupied
    wr_pulse(16'hBEEF, 2);
    n = 0;
    while (tbre && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) fail("reset_tbre_fall_timeout");
    inject(8'h99);
    rst = 1'b0;
    #1;
    exp_cap_q.delete();
    rx_model.delete();
    err_model  = 3'b000;
    hold_until = -1000;
    check("rst_tbre", tbre, 1);
    check("rst_tsre", tsre, 1);
    check("rst_tx_count", tx_count, 0);
    check("rst_cap_valid", cap_valid, 0);
    check("rst_err", err, 0);
    check_rx("rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_tx_count", tx_count, 0);

    // Post-reset sanity
    inject(8'h7E);
    cpu_read();
    check_rx("post_rst_rd");
    cpu_write(16'h0055, 2);
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
